bpsk_word_feeder: RTL and testbench

//  Upstream stage of the BPSK modulator. Buffers words arriving on a valid/ready stream in a sync FIFO.

---
 rtl/bpsk_pkg.sv | 15 +
 rtl/bpsk_sync_fifo.sv | 65 ++++++
 rtl/bpsk_word_feeder.sv | 141 ++++++++++++++
 tb/tb_bpsk_word_feeder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and default constants for the BPSK word feeder and its FIFO.
// The preamble feature of the feeder is enabled with `BPSK_PREAMBLE_EN.
package bpsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } feeder_state_t;

    localparam int         BPSK_DATA_WIDTH    = 8;
    localparam logic [7:0] BPSK_IDLE_WORD     = 8'h00;
    localparam logic [7:0] BPSK_PREAMBLE_WORD = 8'hAA;

endpackage

// File: rtl/bpsk_sync_fifo.sv
// Synchronous FIFO with registered read/write pointers carrying one extra wrap bit,
// so full and empty are distinguished without a separate counter.
module bpsk_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  do_push;
    logic                  do_pop;

    // Same index with differing wrap bits means the write side lapped the read side.
    always_comb begin
        full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        level = wr_ptr_q - rd_ptr_q;
    end

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

endmodule

// File: rtl/bpsk_word_feeder.sv
// Feeds buffered words to the BPSK modulator, holding each for a full symbol frame.
// Define `BPSK_PREAMBLE_EN to prefix every burst with PREAMBLE_LEN copies of PREAMBLE_WORD.
module bpsk_word_feeder
    import bpsk_pkg::*;
#(
    parameter int                    DATA_WIDTH    = BPSK_DATA_WIDTH,
    parameter int                    FIFO_DEPTH    = 16,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = BPSK_IDLE_WORD,
    parameter logic [DATA_WIDTH-1:0] PREAMBLE_WORD = BPSK_PREAMBLE_WORD,
    parameter int                    PREAMBLE_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          mod_finish,
    output logic [DATA_WIDTH-1:0]         mod_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          word_sent,
    output logic                          underrun
);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    feeder_state_t         state_q, state_d;
    logic [DATA_WIDTH-1:0] mod_data_q, mod_data_d;
    logic                  word_sent_q, word_sent_d;
    logic                  underrun_q, underrun_d;

    assign s_ready   = ~fifo_full & ~rst;
    assign fifo_push = s_valid & s_ready;

    bpsk_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (s_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

`ifdef BPSK_PREAMBLE_EN
    localparam int CNT_W = $clog2(PREAMBLE_LEN) + 1;

    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             pre_done;

    assign pre_done = (pre_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
`else
    logic unused_preamble_params;

    assign unused_preamble_params = ^{PREAMBLE_WORD, PREAMBLE_LEN[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mod_data_q  <= IDLE_WORD;
            word_sent_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mod_data_q  <= mod_data_d;
            word_sent_q <= word_sent_d;
            underrun_q  <= underrun_d;
        end
    end

    // Transitions happen only at word boundaries; the empty test is the pre-edge FIFO view.
    always_comb begin
        state_d = state_q;
        if (mod_finish) begin
            if (fifo_empty) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
`ifdef BPSK_PREAMBLE_EN
                    ST_IDLE: state_d = ST_PRE;
                    ST_PRE:  state_d = pre_done ? ST_DATA : ST_PRE;
`else
                    ST_IDLE: state_d = ST_DATA;
`endif
                    ST_DATA: state_d = ST_DATA;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        fifo_pop    = 1'b0;
        mod_data_d  = mod_data_q;
        word_sent_d = 1'b0;
        underrun_d  = 1'b0;
`ifdef BPSK_PREAMBLE_EN
        pre_cnt_d   = pre_cnt_q;
`endif
        if (mod_finish) begin
            if (fifo_empty) begin
                mod_data_d = IDLE_WORD;
                underrun_d = (state_q == ST_DATA);
`ifdef BPSK_PREAMBLE_EN
            end else if (state_q == ST_IDLE) begin
                mod_data_d = PREAMBLE_WORD;
                pre_cnt_d  = CNT_W'(PREAMBLE_LEN - 1);
            end else if (state_q == ST_PRE && !pre_done) begin
                mod_data_d = PREAMBLE_WORD;
                pre_cnt_d  = pre_cnt_q - CNT_W'(1);
`endif
            end else begin
                fifo_pop    = 1'b1;
                mod_data_d  = fifo_rd_data;
                word_sent_d = 1'b1;
            end
        end
    end

    assign mod_data  = mod_data_q;
    assign word_sent = word_sent_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_bpsk_word_feeder.sv
// Directed self-checking bench for bpsk_word_feeder (default 8-bit, 16-deep build).
// With `BPSK_PREAMBLE_EN defined the preamble sequence replaces the plain-data sequences.
module tb_bpsk_word_feeder;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       mod_finish;
    logic [7:0] mod_data;
    logic [4:0] fifo_level;
    logic       word_sent;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    bpsk_word_feeder #(
        .DATA_WIDTH    (8),
        .FIFO_DEPTH    (16),
        .IDLE_WORD     (8'h00),
        .PREAMBLE_WORD (8'hAA),
        .PREAMBLE_LEN  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mod_finish (mod_finish),
        .mod_data   (mod_data),
        .fifo_level (fifo_level),
        .word_sent  (word_sent),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic finish);
        s_valid    = valid;
        s_data     = data;
        mod_finish = finish;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One mod_finish pulse, then check the word loaded and the pulse outputs.
    task automatic finishAndCheck(input string tag, input logic [7:0] exp_data,
                                  input logic exp_sent, input logic exp_under);
        applyStimulus(1'b0, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput({tag, "_data"}, {24'h0, mod_data}, {24'h0, exp_data});
        checkOutput({tag, "_sent"}, {31'h0, word_sent}, {31'h0, exp_sent});
        checkOutput({tag, "_under"}, {31'h0, underrun}, {31'h0, exp_under});
    endtask

    // Idle for n cycles, requiring mod_data steady and no pulses.
    task automatic holdAndCheck(input string tag, input logic [7:0] exp_data, input int n);
        logic stable;
        stable = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (mod_data !== exp_data || word_sent !== 1'b0 || underrun !== 1'b0) stable = 1'b0;
        end
        checkOutput(tag, {31'h0, stable}, 32'h1);
    endtask

    task automatic pushWord(input logic [7:0] data);
        applyStimulus(1'b1, data, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 8'hFF, 1'b0);

        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_ready", {31'h0, s_ready}, 32'h0);
            checkOutput("rst_data", {24'h0, mod_data}, 32'h00);
            checkOutput("rst_level", {27'h0, fifo_level}, 32'h0);
            checkOutput("rst_pulses", {30'h0, word_sent, underrun}, 32'h0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("post_rst_level", {27'h0, fifo_level}, 32'h0);
        checkOutput("post_rst_ready", {31'h0, s_ready}, 32'h1);

`ifdef BPSK_PREAMBLE_EN
        pushWord(8'h11);
        for (int i = 0; i < 4; i++) finishAndCheck("pre1", 8'hAA, 1'b0, 1'b0);
        finishAndCheck("burst1", 8'h11, 1'b1, 1'b0);
        finishAndCheck("burst1_end", 8'h00, 1'b0, 1'b1);
        pushWord(8'h22);
        for (int i = 0; i < 4; i++) finishAndCheck("pre2", 8'hAA, 1'b0, 1'b0);
        finishAndCheck("burst2", 8'h22, 1'b1, 1'b0);
        finishAndCheck("burst2_end", 8'h00, 1'b0, 1'b1);
`else
        // Two words, frame length 32 cycles.
        pushWord(8'hC3);
        pushWord(8'h5A);
        checkOutput("two_level", {27'h0, fifo_level}, 32'h2);
        finishAndCheck("w_c3", 8'hC3, 1'b1, 1'b0);
        checkOutput("c3_level", {27'h0, fifo_level}, 32'h1);
        holdAndCheck("c3_hold", 8'hC3, 31);
        finishAndCheck("w_5a", 8'h5A, 1'b1, 1'b0);
        holdAndCheck("5a_hold", 8'h5A, 31);
        finishAndCheck("w_underrun", 8'h00, 1'b0, 1'b1);
        tick();
        checkOutput("underrun_pulse_end", {31'h0, underrun}, 32'h0);
        finishAndCheck("idle_no_underrun", 8'h00, 1'b0, 1'b0);

        // Fill to full with no pops, then one pop while s_valid stays high.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
            tick();
        end
        checkOutput("full_level", {27'h0, fifo_level}, 32'h10);
        checkOutput("full_ready", {31'h0, s_ready}, 32'h0);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        tick();
        checkOutput("full_hold_level", {27'h0, fifo_level}, 32'h10);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("pop_full_level", {27'h0, fifo_level}, 32'hF);
        checkOutput("pop_full_ready", {31'h0, s_ready}, 32'h1);
        checkOutput("pop_full_data", {24'h0, mod_data}, 32'h10);
        for (int i = 1; i < 16; i++) begin
            finishAndCheck("drain", 8'h10 + 8'(i), 1'b1, 1'b0);
        end
        checkOutput("drain_level", {27'h0, fifo_level}, 32'h0);
        finishAndCheck("drain_underrun", 8'h00, 1'b0, 1'b1);

        // Simultaneous push and pop keeps the level.
        pushWord(8'hA1);
        pushWord(8'hA2);
        finishAndCheck("pp_a1", 8'hA1, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("pp_level", {27'h0, fifo_level}, 32'h1);
        checkOutput("pp_data", {24'h0, mod_data}, 32'hA2);
        finishAndCheck("pp_a3", 8'hA3, 1'b1, 1'b0);
        finishAndCheck("pp_underrun", 8'h00, 1'b0, 1'b1);

        // Push coinciding with mod_finish on an empty FIFO is not bypassed.
        applyStimulus(1'b1, 8'h77, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("nobypass_data", {24'h0, mod_data}, 32'h00);
        checkOutput("nobypass_pulses", {30'h0, word_sent, underrun}, 32'h0);
        checkOutput("nobypass_level", {27'h0, fifo_level}, 32'h1);
        finishAndCheck("nobypass_next", 8'h77, 1'b1, 1'b0);

        // Reset in the middle of a burst with five words buffered.
        for (int i = 0; i < 5; i++) pushWord(8'hB0 + 8'(i));
        finishAndCheck("midrst_b0", 8'hB0, 1'b1, 1'b0);
        pushWord(8'hB5);
        checkOutput("midrst_level_pre", {27'h0, fifo_level}, 32'h5);
        rst = 1'b1;
        tick();
        checkOutput("midrst_level", {27'h0, fifo_level}, 32'h0);
        checkOutput("midrst_data", {24'h0, mod_data}, 32'h00);
        checkOutput("midrst_sent", {31'h0, word_sent}, 32'h0);
        checkOutput("midrst_ready", {31'h0, s_ready}, 32'h0);
        rst = 1'b0;
        tick();
        finishAndCheck("after_midrst", 8'h00, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
